// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning path: FSM encoding,
// board clock rate and the default timing constants derived from it.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int CLK_HZ        = 50000000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int REPEAT_500MS  = CLK_HZ / 2;
  localparam int REPEAT_200MS  = CLK_HZ / 5;

  // Counters only ever hold (limit - 1), so $clog2 of the largest limit is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset
// to RST_VAL so the downstream logic sees a known idle level out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces an active-low push button and turns it into single-cycle press,
// release and auto-repeat pulses on the board clock.
//
// state        | meaning
// IDLE         | key released and stable
// PRESS_WAIT   | key seen pressed, counting stable cycles before accepting
// HELD         | press accepted; auto-repeat timer runs here
// RELEASE_WAIT | key seen released, counting stable cycles; repeat timer paused
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_RATE     = REPEAT_200MS
) (
  input  logic clk,
  input  logic clr,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int           W         = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam bit           REPEAT_ON = (REPEAT_DELAY != 0);
  localparam logic [W-1:0] DEB_LAST  = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] DLY_LAST  = REPEAT_ON ? W'(REPEAT_DELAY - 1) : '0;
  localparam logic [W-1:0] RATE_LAST = (REPEAT_RATE > 0) ? W'(REPEAT_RATE - 1) : '0;

  logic       key_sync;
  logic       key_s;
  key_state_e state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic       rpt_rate_q, rpt_rate_d;
  logic       level_d, press_d, release_d, repeat_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .clr (clr),
    .d   (key_n),
    .q   (key_sync)
  );

  assign key_s = ~key_sync;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rpt_cnt_q     <= '0;
      rpt_rate_q    <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      step_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_rate_q    <= rpt_rate_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
      step_pulse    <= press_d | repeat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    rpt_rate_d = rpt_rate_q;
    level_d    = level;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          level_d    = 1'b1;
          rpt_cnt_d  = '0;
          rpt_rate_d = 1'b0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (REPEAT_ON) begin
          // First target is the initial delay, every later one is the rate.
          if (rpt_cnt_q == (rpt_rate_q ? RATE_LAST : DLY_LAST)) begin
            repeat_d   = 1'b1;
            rpt_cnt_d  = '0;
            rpt_rate_d = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scenario bench for key_debounce_pulse: expected pulse events are queued with
// their edge numbers as stimulus is planned and matched as the DUT emits them.
module tb_key_debounce_pulse;
  import key_pkg::*;

  logic clk = 1'b0;
  logic clr;
  logic key_n;
  logic level, press_pulse, release_pulse, repeat_pulse, step_pulse;
  logic nr_level, nr_press, nr_release, nr_repeat, nr_step;
  logic d1_level, d1_press, d1_release, d1_repeat, d1_step;

  key_debounce_pulse #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut (
    .clk(clk), .clr(clr), .key_n(key_n), .level(level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .step_pulse(step_pulse));

  key_debounce_pulse #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(3)) dut_nr (
    .clk(clk), .clr(clr), .key_n(key_n), .level(nr_level), .press_pulse(nr_press),
    .release_pulse(nr_release), .repeat_pulse(nr_repeat), .step_pulse(nr_step));

  key_debounce_pulse #(.DEBOUNCE_CYCLES(1), .REPEAT_DELAY(0), .REPEAT_RATE(1)) dut_d1 (
    .clk(clk), .clr(clr), .key_n(key_n), .level(d1_level), .press_pulse(d1_press),
    .release_pulse(d1_release), .repeat_pulse(d1_repeat), .step_pulse(d1_step));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int edge_n;
    bit press;
    bit rel;
    bit rpt;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  base     = 0;

  task automatic push(input int e, input bit p, input bit r, input bit t);
    ev_t ev;
    ev.edge_n = e; ev.press = p; ev.rel = r; ev.rpt = t;
    sb.push_back(ev);
  endtask

  // Scoreboard monitor on the main DUT.
  always @(negedge clk) begin
    ev_t ev;
    if (press_pulse || release_pulse || repeat_pulse || step_pulse) begin
      n_checks++;
      if ($countones({press_pulse, release_pulse, repeat_pulse}) > 1) begin
        n_fail++;
        $display("FAIL exclusive at edge %0d: press=%b release=%b repeat=%b, required at most one high",
                 cyc, press_pulse, release_pulse, repeat_pulse);
      end
      while (sb.size() > 0 && sb[0].edge_n < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL missed_event: required at edge %0d press=%b release=%b repeat=%b, not observed by the monitor",
                 sb[0].edge_n, sb[0].press, sb[0].rel, sb[0].rpt);
        void'(sb.pop_front());
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse at edge %0d: press=%b release=%b repeat=%b step=%b, required none",
                 cyc, press_pulse, release_pulse, repeat_pulse, step_pulse);
      end else begin
        ev = sb.pop_front();
        if (ev.edge_n != cyc || press_pulse !== ev.press || release_pulse !== ev.rel ||
            repeat_pulse !== ev.rpt || step_pulse !== (ev.press | ev.rpt)) begin
          n_fail++;
          $display("FAIL sb_event at edge %0d: press=%b release=%b repeat=%b step=%b, required edge %0d press=%b release=%b repeat=%b step=%b",
                   cyc, press_pulse, release_pulse, repeat_pulse, step_pulse,
                   ev.edge_n, ev.press, ev.rel, ev.rpt, ev.press | ev.rpt);
        end
      end
    end
  end

  task automatic test_reset;
    clr = 1'b1; key_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({level, press_pulse, release_pulse, repeat_pulse, step_pulse} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {level, press_pulse, release_pulse, repeat_pulse, step_pulse});
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d, required IDLE", dut.state_q);
    end
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_press;
    key_n = 1'b0; base = cyc;
    push(base + 7, 1, 0, 0);
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      n_checks++;
      if (level !== (e >= 7) || repeat_pulse !== 1'b0) begin
        n_fail++; $display("FAIL press_level edge %0d: level=%b repeat=%b, required level=%b repeat=0",
                           e, level, repeat_pulse, e >= 7);
      end
      n_checks++;
      if (d1_press !== (e == 4) || d1_step !== (e == 4) || d1_level !== (e >= 4) ||
          d1_repeat !== 1'b0 || d1_release !== 1'b0) begin
        n_fail++; $display("FAIL deb1_press edge %0d: press=%b step=%b level=%b, required %b %b %b",
                           e, d1_press, d1_step, d1_level, e == 4, e == 4, e >= 4);
      end
    end
  endtask

  task automatic test_hold_repeat;
    for (int k = 0; k < 7; k++) push(base + 17 + 3 * k, 0, 0, 1);
    for (int e = 17; e <= 37; e++) begin
      @(negedge clk);
      n_checks++;
      if (level !== 1'b1 || step_pulse !== ((e - 17) % 3 == 0 && e <= 35)) begin
        n_fail++; $display("FAIL hold_repeat edge %0d: level=%b step=%b, required level=1 step=%b",
                           e, level, step_pulse, (e - 17) % 3 == 0 && e <= 35);
      end
    end
  endtask

  task automatic test_release_glitch;
    // One-cycle release at 38 pauses the repeat timer (next repeat 43, not 41),
    // then high 2 / low 1 / high stable gives a single release at 55.
    push(base + 38, 0, 0, 1);
    push(base + 43, 0, 0, 1);
    push(base + 46, 0, 0, 1);
    push(base + 55, 0, 1, 0);
    for (int e = 38; e <= 62; e++) begin
      key_n = (e == 38) || (e >= 46 && e != 48);
      @(negedge clk);
      n_checks++;
      if (level !== (e < 55)) begin
        n_fail++; $display("FAIL release_level edge %0d: level=%b, required %b", e, level, e < 55);
      end
    end
    n_checks++;
    if (sb.size() != 0 || dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL release_done: pending=%0d state=%0d, required 0 and IDLE",
                         sb.size(), dut.state_q);
    end
  endtask

  task automatic test_bounce;
    repeat (2) @(negedge clk);
    base = cyc;
    for (int e = 1; e <= 16; e++) begin
      key_n = !(e == 1 || e == 2 || e == 4 || e == 5);
      @(negedge clk);
      n_checks++;
      if (level !== 1'b0 || press_pulse !== 1'b0) begin
        n_fail++; $display("FAIL bounce edge %0d: level=%b press=%b, required 0 0", e, level, press_pulse);
      end
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL bounce_state: got %0d, required IDLE", dut.state_q);
    end
  endtask

  task automatic test_repeat_disabled;
    int steps, step_edge, rels;
    steps = 0; step_edge = -1; rels = 0;
    base = cyc;
    push(base + 7, 1, 0, 0);
    for (int k = 0; k <= 28; k++) push(base + 17 + 3 * k, 0, 0, 1);
    push(base + 107, 0, 1, 0);
    for (int e = 1; e <= 120; e++) begin
      key_n = (e > 100);
      @(negedge clk);
      if (nr_step) begin steps++; step_edge = e; end
      if (nr_release) rels++;
      n_checks++;
      if (nr_repeat !== 1'b0 || nr_press !== nr_step) begin
        n_fail++; $display("FAIL norepeat edge %0d: repeat=%b press=%b step=%b, required repeat=0 press==step",
                           e, nr_repeat, nr_press, nr_step);
      end
    end
    n_checks++;
    if (steps != 1 || step_edge != 7 || rels != 1 || nr_level !== 1'b0) begin
      n_fail++; $display("FAIL norepeat_count: steps=%0d at edge %0d releases=%0d level=%b, required 1 at 7, 1, 0",
                         steps, step_edge, rels, nr_level);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL norepeat_pending: %0d events outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_midop;
    key_n = 1'b0; base = cyc;
    repeat (5) @(negedge clk);
    n_checks++;
    if (dut.state_q !== PRESS_WAIT || dut.cnt_q !== 4'd2) begin
      n_fail++; $display("FAIL midop_pw: state=%0d cnt=%0d, required PRESS_WAIT 2", dut.state_q, dut.cnt_q);
    end
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== 4'd0 || level !== 1'b0 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL midop_pw_clr: state=%0d cnt=%0d level=%b step=%b, required IDLE 0 0 0",
                         dut.state_q, dut.cnt_q, level, step_pulse);
    end
    repeat (3) @(negedge clk);
    clr = 1'b0; base = cyc;
    push(base + 7, 1, 0, 0);
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      n_checks++;
      if (press_pulse !== (e == 7) || level !== (e == 7)) begin
        n_fail++; $display("FAIL midop_repress edge %0d: press=%b level=%b, required %b %b",
                           e, press_pulse, level, e == 7, e == 7);
      end
    end
    // clr lands while press_pulse and level are high.
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({level, press_pulse, release_pulse, repeat_pulse, step_pulse} !== 5'b0) begin
      n_fail++; $display("FAIL midop_held_clr: got %b, required 00000",
                         {level, press_pulse, release_pulse, repeat_pulse, step_pulse});
    end
    repeat (2) @(negedge clk);
    clr = 1'b0; base = cyc;
    push(base + 7, 1, 0, 0);
    push(base + 14, 0, 1, 0);
    for (int e = 1; e <= 20; e++) begin
      key_n = (e >= 8);
      @(negedge clk);
      n_checks++;
      if (level !== (e >= 7 && e < 14)) begin
        n_fail++; $display("FAIL midop_level edge %0d: level=%b, required %b", e, level, e >= 7 && e < 14);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_hold_repeat();
    test_release_glitch();
    test_bounce();
    test_repeat_disabled();
    test_reset_midop();
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL final_pending: %0d events outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
